// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the two-phase toggle handshake transmitter.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } hs_state_t;

    localparam int SETUP_CNT_W     = 4;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_sync_nff.sv
// Plain N-flop synchronizer chain with asynchronous clear.
module cdc_sync_nff #(
    parameter int DW     = 1,
    parameter int STAGES = 2
) (
    input  logic          CP,
    input  logic          CLR,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] sync_q [STAGES];

    // NOTE: every stage is cleared on CLR so no stale toggle survives a reset in the chain.
    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit side of a two-phase toggle handshake: captures a word, holds it,
// toggles xfer_req after a settle time and waits for the synchronized ack toggle.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 1
) (
    input  logic          CP,
    input  logic          CLR,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          src_done,
    output logic [DW-1:0] xfer_data,
    output logic          xfer_req,
    input  logic          xfer_ack,
    output logic          err_spurious
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("cdc_hs_tx: SYNC_STAGES out of range");
    end
    if (SETUP_CYC < 0 || SETUP_CYC > (2**SETUP_CNT_W) - 1) begin : g_bad_setup
        $error("cdc_hs_tx: SETUP_CYC out of range");
    end

    localparam logic [SETUP_CNT_W-1:0] CNT_INIT =
        (SETUP_CYC == 0) ? '0 : SETUP_CNT_W'(SETUP_CYC - 1);

    hs_state_t              state, state_nxt;
    logic [SETUP_CNT_W-1:0] cnt;
    logic                   ack_s, ack_d;
    logic                   capture, launch, done;

    cdc_sync_nff #(
        .DW     (1),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .CP  (CP),
        .CLR (CLR),
        .d   (xfer_ack),
        .q   (ack_s)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (capture) state_nxt = (SETUP_CYC == 0) ? WAIT_ACK : SETUP;
            SETUP:    if (cnt == '0) state_nxt = WAIT_ACK;
            WAIT_ACK: if (done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Decoded strobes; a completion is only recognised while a request is outstanding.
    always_comb begin
        src_ready = (state == IDLE);
        capture   = src_ready & src_valid;
        launch    = (capture && SETUP_CYC == 0) || (state == SETUP && cnt == '0);
        done      = (state == WAIT_ACK) && (ack_s == xfer_req);
    end

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) begin
            xfer_data    <= '0;
            xfer_req     <= 1'b0;
            cnt          <= '0;
            src_done     <= 1'b0;
            ack_d        <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            src_done <= done;
            ack_d    <= ack_s;
            if (capture) begin
                xfer_data <= src_data;
                cnt       <= CNT_INIT;
            end else if (state == SETUP && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (launch) xfer_req <= ~xfer_req;
            // Any ack edge with no request outstanding is remembered until reset.
            if ((state == IDLE || state == SETUP) && ack_s != ack_d) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: handshake timing, setup extremes, spurious ack and reset.
module tb_cdc_hs_tx;

    logic        CP  = 1'b0;
    logic        CLR = 1'b0;

    logic        src_valid = 1'b0;
    logic [31:0] src_data  = '0;
    logic        src_ready, src_done, xfer_req, err_spurious;
    logic [31:0] xfer_data;
    logic        xfer_ack = 1'b0;

    logic        v0 = 1'b0, v15 = 1'b0;
    logic [31:0] d0 = '0, d15 = '0;
    logic        rdy0, done0, req0, err0, rdy15, done15, req15, err15;
    logic [31:0] xd0, xd15;
    logic        ack_z = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CP = ~CP;

    cdc_hs_tx #(.DW(32), .SYNC_STAGES(2), .SETUP_CYC(1)) u_dut (
        .CP(CP), .CLR(CLR), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .src_done(src_done), .xfer_data(xfer_data),
        .xfer_req(xfer_req), .xfer_ack(xfer_ack), .err_spurious(err_spurious)
    );

    cdc_hs_tx #(.DW(32), .SYNC_STAGES(2), .SETUP_CYC(0)) u_dut0 (
        .CP(CP), .CLR(CLR), .src_valid(v0), .src_data(d0),
        .src_ready(rdy0), .src_done(done0), .xfer_data(xd0),
        .xfer_req(req0), .xfer_ack(ack_z), .err_spurious(err0)
    );

    cdc_hs_tx #(.DW(32), .SYNC_STAGES(2), .SETUP_CYC(15)) u_dut15 (
        .CP(CP), .CLR(CLR), .src_valid(v15), .src_data(d15),
        .src_ready(rdy15), .src_done(done15), .xfer_data(xd15),
        .xfer_req(req15), .xfer_ack(ack_z), .err_spurious(err15)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic reset_all();
        CLR       = 1'b0;
        src_valid = 1'b0;
        v0        = 1'b0;
        v15       = 1'b0;
        xfer_ack  = 1'b0;
        repeat (2) tick();
        CLR = 1'b1;
    endtask

    // One complete word on the main instance, destination answering after two cycles.
    task automatic do_xfer(input logic [31:0] w, input string tag);
        int   t;
        logic req_before;
        logic req_exp;
        req_before = xfer_req;
        req_exp    = ~req_before;
        check({tag, "_ready"}, {31'b0, src_ready}, 32'd1);
        src_data  = w;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        check({tag, "_data"}, xfer_data, w);
        t = 0;
        while (xfer_req == req_before && t < 20) begin
            tick();
            t++;
        end
        check({tag, "_req"}, {31'b0, xfer_req}, {31'b0, req_exp});
        repeat (2) tick();
        xfer_ack = xfer_req;
        t = 0;
        while (!src_done && t < 10) begin
            tick();
            t++;
        end
        check({tag, "_done"}, {31'b0, src_done}, 32'd1);
        check({tag, "_lat"}, t, 32'd3);
        check({tag, "_idle"}, {31'b0, src_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [3];
        logic        exp_req [3];
        logic [31:0] last;
        logic        rdy_pre, val_pre;
        int          k, n_done, t, ack_cnt;

        // 1: reset state
        reset_all();
        tick();
        check("t1_ready", {31'b0, src_ready}, 32'd1);
        check("t1_req", {31'b0, xfer_req}, 32'd0);
        check("t1_data", xfer_data, 32'd0);
        check("t1_err", {31'b0, err_spurious}, 32'd0);
        check("t1_done", {31'b0, src_done}, 32'd0);

        // 4: SETUP_CYC=0 toggles on the capture edge, SETUP_CYC=15 fifteen edges later
        d0  = 32'h0000_00F0;
        d15 = 32'h0000_0F15;
        v0  = 1'b1;
        v15 = 1'b1;
        tick();
        v0  = 1'b0;
        v15 = 1'b0;
        check("t4_req0", {31'b0, req0}, 32'd1);
        check("t4_data0", xd0, 32'h0000_00F0);
        check("t4_rdy0", {31'b0, rdy0}, 32'd0);
        check("t4_req15_e0", {31'b0, req15}, 32'd0);
        for (int i = 1; i < 15; i++) begin
            tick();
            check($sformatf("t4_req15_e%0d", i), {31'b0, req15}, 32'd0);
        end
        tick();
        check("t4_req15_e15", {31'b0, req15}, 32'd1);
        check("t4_rdy15", {31'b0, rdy15}, 32'd0);
        check("t4_data15", xd15, 32'h0000_0F15);
        check("t4_err", {30'b0, err0, err15}, 32'd0);
        check("t4_done", {30'b0, done0, done15}, 32'd0);

        // 2: single word, SETUP_CYC=1, ack four cycles after req
        src_data  = 32'hA5A5_0001;
        src_valid = 1'b1;
        tick();
        src_data = 32'hDEAD_BEEF;
        check("t2_ready_low", {31'b0, src_ready}, 32'd0);
        check("t2_req_pre", {31'b0, xfer_req}, 32'd0);
        check("t2_data_cap", xfer_data, 32'hA5A5_0001);
        tick();
        check("t2_req_toggle", {31'b0, xfer_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_data_hold", xfer_data, 32'hA5A5_0001);
        end
        xfer_ack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t2_done_c%0d", i), {31'b0, src_done}, (i == 3) ? 32'd1 : 32'd0);
            check("t2_data_wait", xfer_data, 32'hA5A5_0001);
            if (i == 3) begin
                check("t2_ready_back", {31'b0, src_ready}, 32'd1);
                src_valid = 1'b0;
            end
        end
        check("t2_err", {31'b0, err_spurious}, 32'd0);

        // 3: three back-to-back words with src_valid held high
        reset_all();
        words   = '{32'd1, 32'd2, 32'd3};
        exp_req = '{1'b1, 1'b0, 1'b1};
        k = 0; n_done = 0; t = 0; ack_cnt = 0; last = '0;
        src_data  = words[0];
        src_valid = 1'b1;
        while (n_done < 3 && t < 300) begin
            rdy_pre = src_ready;
            val_pre = src_valid;
            tick();
            t++;
            if (rdy_pre && val_pre) begin
                check($sformatf("t3_cap%0d", k), xfer_data, words[k]);
                last = words[k];
                k++;
                if (k < 3) src_data = words[k];
                else       src_valid = 1'b0;
            end else begin
                check("t3_hold", xfer_data, last);
            end
            if (src_done) begin
                check($sformatf("t3_req%0d", n_done), {31'b0, xfer_req}, {31'b0, exp_req[n_done]});
                n_done++;
            end
            if (xfer_req != xfer_ack) begin
                if (ack_cnt == 2) begin
                    xfer_ack = xfer_req;
                    ack_cnt  = 0;
                end else begin
                    ack_cnt++;
                end
            end
        end
        src_valid = 1'b0;
        check("t3_ndone", n_done, 32'd3);
        check("t3_ncap", k, 32'd3);
        check("t3_err", {31'b0, err_spurious}, 32'd0);

        // 5: spurious ack toggle in IDLE, sticky across a good transfer, cleared by CLR
        tick();
        xfer_ack = ~xfer_ack;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("t5_err_c%0d", i), {31'b0, err_spurious}, (i == 3) ? 32'd1 : 32'd0);
        end
        xfer_ack = ~xfer_ack;
        repeat (4) tick();
        do_xfer(32'h5555_0005, "t5_xfer");
        tick();
        check("t5_err_sticky", {31'b0, err_spurious}, 32'd1);
        CLR      = 1'b0;
        xfer_ack = 1'b0;
        #1;
        check("t5_err_clr", {31'b0, err_spurious}, 32'd0);
        tick();
        CLR = 1'b1;
        tick();

        // 6: asynchronous reset during WAIT_ACK with xfer_req=1
        xfer_ack = 1'b1;
        repeat (3) tick();
        xfer_ack = 1'b0;
        repeat (3) tick();
        check("t6_err_pre", {31'b0, err_spurious}, 32'd1);
        src_data  = 32'h6666_0006;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        tick();
        check("t6_req_pre", {31'b0, xfer_req}, 32'd1);
        tick();
        check("t6_data_pre", xfer_data, 32'h6666_0006);
        #2;
        CLR = 1'b0;
        #1;
        check("t6_req_rst", {31'b0, xfer_req}, 32'd0);
        check("t6_data_rst", xfer_data, 32'd0);
        check("t6_err_rst", {31'b0, err_spurious}, 32'd0);
        check("t6_ready_rst", {31'b0, src_ready}, 32'd1);
        repeat (2) tick();
        CLR = 1'b1;
        tick();
        do_xfer(32'h7777_0007, "t6_xfer");
        tick();
        check("t6_err_post", {31'b0, err_spurious}, 32'd0);
        check("t6_req_post", {31'b0, xfer_req}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
